pc_gen: RTL and testbench

//  Registered next-PC generator at the head of fetch. Arbitrates NUM_REDIRECT prioritised

---
 rtl/pc_gen.sv | 90 +++++++++
 tb/tb_pc_gen.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - registered next-PC generator with prioritised redirect arbitration
// A pending slot holds the best redirect seen while fetch is back-pressured.
module pc_gen #(
    parameter int              NUM_REDIRECT = 6,
    parameter int              FETCH_WIDTH  = 2,
    parameter int              PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = 32'hbfc00000,
    localparam int             IDX_W        = (NUM_REDIRECT > 1) ? $clog2(NUM_REDIRECT) : 1
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic [NUM_REDIRECT-1:0]          redir_valid,
    input  logic [NUM_REDIRECT*PC_WIDTH-1:0] redir_pc,
    input  logic                             fetch_ready,
    output logic                             fetch_valid,
    output logic [PC_WIDTH-1:0]              fetch_pc,
    output logic                             fetch_adel,
    output logic                             pend_valid,
    output logic [IDX_W-1:0]                 pend_idx
);

    localparam logic [PC_WIDTH-1:0] SEQ_STEP = PC_WIDTH'(4 * FETCH_WIDTH);
    localparam logic [PC_WIDTH-1:0] SEQ_MASK = ~(SEQ_STEP - PC_WIDTH'(1));

    logic                r_fetch_valid;
    logic [PC_WIDTH-1:0] r_fetch_pc;
    logic                r_fetch_adel;
    logic                r_pend_valid;
    logic [IDX_W-1:0]    r_pend_idx;
    logic [PC_WIDTH-1:0] r_pend_pc;

    logic                w_accept;
    logic                w_live_valid;
    logic [IDX_W-1:0]    w_live_idx;
    logic [PC_WIDTH-1:0] w_live_pc;
    logic                w_live_wins;
    logic                w_cand_valid;
    logic [PC_WIDTH-1:0] w_cand_pc;
    logic [PC_WIDTH-1:0] w_seq_pc;
    logic [PC_WIDTH-1:0] w_next_pc;

    always_comb begin
        w_live_valid = |redir_valid;
        w_live_idx   = '0;
        w_live_pc    = '0;
        // Scan downward so the lowest-index request is the one left standing.
        for (int i = NUM_REDIRECT - 1; i >= 0; i--) begin
            if (redir_valid[i]) begin
                w_live_idx = IDX_W'(i);
                w_live_pc  = redir_pc[i*PC_WIDTH +: PC_WIDTH];
            end
        end
        // Ties on index go to the live request since it carries the newer target.
        w_live_wins  = w_live_valid && (!r_pend_valid || (w_live_idx <= r_pend_idx));
        w_cand_valid = w_live_valid || r_pend_valid;
        w_cand_pc    = w_live_wins ? w_live_pc : r_pend_pc;
        w_accept     = r_fetch_valid && fetch_ready;
        w_seq_pc     = (r_fetch_pc & SEQ_MASK) + SEQ_STEP;
        w_next_pc    = w_cand_valid ? w_cand_pc : w_seq_pc;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_fetch_valid <= 1'b0;
            r_fetch_pc    <= RESET_PC;
            r_fetch_adel  <= 1'b0;
            r_pend_valid  <= 1'b0;
            r_pend_idx    <= '0;
            r_pend_pc     <= '0;
        end else begin
            r_fetch_valid <= 1'b1;
            if (w_accept) begin
                r_fetch_pc   <= w_next_pc;
                r_fetch_adel <= (w_next_pc[1:0] != 2'b00);
                r_pend_valid <= 1'b0;
            end else if (w_live_wins) begin
                r_pend_valid <= 1'b1;
                r_pend_idx   <= w_live_idx;
                r_pend_pc    <= w_live_pc;
            end
        end
    end

    assign fetch_valid = r_fetch_valid;
    assign fetch_pc    = r_fetch_pc;
    assign fetch_adel  = r_fetch_adel;
    assign pend_valid  = r_pend_valid;
    assign pend_idx    = r_pend_idx;

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - directed self-checking bench for pc_gen
module tb_pc_gen;

    localparam int NR = 6;
    localparam int PW = 32;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic [NR-1:0]     redir_valid = '0;
    logic [NR*PW-1:0]  redir_pc = '0;
    logic              fetch_ready = 1'b0;
    logic              fetch_valid;
    logic [PW-1:0]     fetch_pc;
    logic              fetch_adel;
    logic              pend_valid;
    logic [2:0]        pend_idx;

    int n_checks = 0;
    int n_fail   = 0;

    pc_gen #(
        .NUM_REDIRECT(NR),
        .FETCH_WIDTH (2),
        .PC_WIDTH    (PW),
        .RESET_PC    (32'hbfc00000)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .redir_valid(redir_valid),
        .redir_pc   (redir_pc),
        .fetch_ready(fetch_ready),
        .fetch_valid(fetch_valid),
        .fetch_pc   (fetch_pc),
        .fetch_adel (fetch_adel),
        .pend_valid (pend_valid),
        .pend_idx   (pend_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_redir(input int ch, input logic [31:0] pc);
        redir_valid[ch]       = 1'b1;
        redir_pc[ch*PW +: PW] = pc;
    endtask

    task automatic clr_redir();
        redir_valid = '0;
        redir_pc    = '0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        step();
        step();
        resetn = 1'b1;
    endtask

    initial begin
        // 1: reset state and sequential packet stepping
        fetch_ready = 1'b1;
        step();
        check("rst_pc", fetch_pc, 32'hbfc00000);
        check("rst_valid", {31'd0, fetch_valid}, 32'd0);
        check("rst_pend", {31'd0, pend_valid}, 32'd0);
        check("rst_idx", {29'd0, pend_idx}, 32'd0);
        check("rst_adel", {31'd0, fetch_adel}, 32'd0);
        resetn = 1'b1;
        step();
        check("t1_valid", {31'd0, fetch_valid}, 32'd1);
        check("t1_pc0", fetch_pc, 32'hbfc00000);
        step();
        check("t1_pc1", fetch_pc, 32'hbfc00008);
        step();
        check("t1_pc2", fetch_pc, 32'hbfc00010);

        // 2: two live redirects, ch1 beats ch2
        do_reset();
        step();
        step();
        check("t2_pre", fetch_pc, 32'hbfc00008);
        set_redir(1, 32'h80000180);
        set_redir(2, 32'hbfc00100);
        step();
        clr_redir();
        check("t2_pc", fetch_pc, 32'h80000180);
        check("t2_pend", {31'd0, pend_valid}, 32'd0);

        // 3: back-pressure buffering, replace on higher priority, drop on lower
        fetch_ready = 1'b0;
        set_redir(4, 32'hbfc00200);
        step();
        clr_redir();
        check("t3_idx0", {29'd0, pend_idx}, 32'd4);
        check("t3_pv0", {31'd0, pend_valid}, 32'd1);
        set_redir(2, 32'hbfc00300);
        step();
        clr_redir();
        check("t3_idx1", {29'd0, pend_idx}, 32'd2);
        set_redir(5, 32'hbfc00400);
        step();
        clr_redir();
        check("t3_idx2", {29'd0, pend_idx}, 32'd2);
        check("t3_hold", fetch_pc, 32'h80000180);
        fetch_ready = 1'b1;
        step();
        check("t3_pc", fetch_pc, 32'hbfc00300);
        check("t3_pend", {31'd0, pend_valid}, 32'd0);

        // 4: live request on same index as pending wins
        fetch_ready = 1'b0;
        set_redir(2, 32'hbfc00300);
        step();
        clr_redir();
        check("t4_pv", {31'd0, pend_valid}, 32'd1);
        fetch_ready = 1'b1;
        set_redir(2, 32'hbfc00500);
        step();
        clr_redir();
        check("t4_pc", fetch_pc, 32'hbfc00500);
        check("t4_pend", {31'd0, pend_valid}, 32'd0);

        // 5: misaligned target issued unmodified, sequential realigns
        set_redir(3, 32'hbfc00106);
        step();
        clr_redir();
        check("t5_pc", fetch_pc, 32'hbfc00106);
        check("t5_adel", {31'd0, fetch_adel}, 32'd1);
        step();
        check("t5_seq", fetch_pc, 32'hbfc00108);
        check("t5_adel0", {31'd0, fetch_adel}, 32'd0);

        // 6: wrap at top of address space, then async reset with pending set
        set_redir(0, 32'hfffffff8);
        step();
        clr_redir();
        check("t6_top", fetch_pc, 32'hfffffff8);
        step();
        check("t6_wrap", fetch_pc, 32'h00000000);
        fetch_ready = 1'b0;
        set_redir(1, 32'h12345678);
        step();
        clr_redir();
        check("t6_pv", {31'd0, pend_valid}, 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("t6_rst_pc", fetch_pc, 32'hbfc00000);
        check("t6_rst_pv", {31'd0, pend_valid}, 32'd0);
        check("t6_rst_vld", {31'd0, fetch_valid}, 32'd0);
        step();
        resetn = 1'b1;
        fetch_ready = 1'b1;
        step();
        check("t6_rel_pc", fetch_pc, 32'hbfc00000);
        check("t6_rel_pv", {31'd0, pend_valid}, 32'd0);
        step();
        check("t6_rel_seq", fetch_pc, 32'hbfc00008);

        // 7: redirect seen in the first cycle out of reset is buffered, RESET_PC issued first
        do_reset();
        set_redir(3, 32'h9fc00040);
        step();
        clr_redir();
        check("t7_pc", fetch_pc, 32'hbfc00000);
        check("t7_pv", {31'd0, pend_valid}, 32'd1);
        check("t7_idx", {29'd0, pend_idx}, 32'd3);
        step();
        check("t7_issue", fetch_pc, 32'h9fc00040);
        check("t7_pv0", {31'd0, pend_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
